// File: rtl/port_arbiter.sv
// Output-port arbiter for a wormhole router.
// Round-robin choice among requesting inputs, then the port stays locked to the
// winner until its tail flit moves or the packet reaches MAX_PKT flits.

module port_arbiter #(
    parameter int unsigned N_IN    = 5,
    parameter int unsigned MAX_PKT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N_IN-1:0] req,
    input  logic [N_IN-1:0] tail,
    input  logic            out_ready,
    output logic [N_IN-1:0] grant,
    output logic [2:0]      sel,
    output logic            xfer,
    output logic            pkt_err
);

    localparam int unsigned SelW    = 3;
    localparam int unsigned CntW    = 8;
    localparam logic [CntW-1:0] LastCnt = CntW'(MAX_PKT - 1);

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   grant_q, grant_d;
    logic [SelW-1:0]   sel_q, sel_d;
    logic [SelW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]   flit_cnt_q, flit_cnt_d;
    logic              pkt_err_q, pkt_err_d;

    logic              pick_valid;
    logic [SelW-1:0]   pick_idx;
    logic              owner_req;
    logic              owner_tail;
    logic              xfer_int;
    logic              pkt_end;
    int unsigned       idx;

    // Round-robin search: first set req bit starting just after the last owner.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int unsigned i = 1; i <= N_IN; i++) begin
            idx = (int'(rr_ptr_q) + i) % N_IN;
            if (!pick_valid && req[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = SelW'(idx);
            end
        end
    end

    // Owner-qualified request/tail; grant is one-hot so masking equals indexing by sel.
    always_comb begin
        owner_req  = |(req & grant_q);
        owner_tail = |(tail & grant_q);
        xfer_int   = en & (state_q == StBusy) & owner_req & out_ready;
        pkt_end    = owner_tail | (flit_cnt_q == LastCnt);
    end

    // Next-state logic: arbitrate when idle, count flits and release when busy.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        rr_ptr_d   = rr_ptr_q;
        flit_cnt_d = flit_cnt_q;
        pkt_err_d  = pkt_err_q;
        unique case (state_q)
            StIdle: begin
                if (en && pick_valid) begin
                    state_d    = StBusy;
                    grant_d    = N_IN'(1) << pick_idx;
                    sel_d      = pick_idx;
                    flit_cnt_d = '0;
                end
            end
            StBusy: begin
                if (xfer_int) begin
                    flit_cnt_d = flit_cnt_q + 1'b1;
                    if (pkt_end) begin
                        // Release; the following IDLE cycle re-arbitrates.
                        state_d  = StIdle;
                        grant_d  = '0;
                        sel_d    = '0;
                        rr_ptr_d = sel_q;
                        if (!owner_tail) begin
                            pkt_err_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
                sel_d   = '0;
            end
        endcase
    end

    // State register with asynchronous active-low reset; en=0 freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            sel_q      <= '0;
            rr_ptr_q   <= SelW'(N_IN - 1);
            flit_cnt_q <= '0;
            pkt_err_q  <= 1'b0;
        end else if (en) begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            rr_ptr_q   <= rr_ptr_d;
            flit_cnt_q <= flit_cnt_d;
            pkt_err_q  <= pkt_err_d;
        end
    end

    // Drive outputs; xfer is gated by rst_n so nothing moves while reset is held.
    always_comb begin
        grant   = grant_q;
        sel     = sel_q;
        xfer    = xfer_int & rst_n;
        pkt_err = pkt_err_q;
    end

    // Structural invariants of the lock.
    a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
    a_busy_has_owner : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == StBusy) == (grant_q != '0));

endmodule

// File: tb/tb_port_arbiter.sv
// Directed bench for port_arbiter, built with MAX_PKT=4 so forced release is short.

module tb_port_arbiter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [4:0] req;
    logic [4:0] tail;
    logic       out_ready;
    logic [4:0] grant;
    logic [2:0] sel;
    logic       xfer;
    logic       pkt_err;

    int tests;
    int fails;

    port_arbiter #(
        .N_IN    (5),
        .MAX_PKT (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .tail      (tail),
        .out_ready (out_ready),
        .grant     (grant),
        .sel       (sel),
        .xfer      (xfer),
        .pkt_err   (pkt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        en        = 1'b1;
        req       = '0;
        tail      = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        tests++;
        if (grant !== 5'b00000) begin
            fails++; $display("FAIL reset_grant: got %b want %b", grant, 5'b00000);
        end
        tests++;
        if (sel !== 3'd0) begin
            fails++; $display("FAIL reset_sel: got %0d want 0", sel);
        end
        tests++;
        if (xfer !== 1'b0 || pkt_err !== 1'b0) begin
            fails++; $display("FAIL reset_flags: xfer=%b pkt_err=%b want 0 0", xfer, pkt_err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_first_grant();
        do_reset();
        req       = 5'b10110;
        out_ready = 1'b1;
        #1;
        tests++;
        if (grant !== 5'b00000) begin
            fails++; $display("FAIL first_grant_latency: got %b want %b", grant, 5'b00000);
        end
        tick();
        tests++;
        if (grant !== 5'b00010 || sel !== 3'd1) begin
            fails++; $display("FAIL first_grant: grant=%b sel=%0d want 00010 1", grant, sel);
        end
        tests++;
        if (xfer !== 1'b1) begin
            fails++; $display("FAIL first_xfer: got %b want 1", xfer);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req       = 5'b10110;
        out_ready = 1'b1;
        tick();                     // owner 1, flit 1 offered
        tick();                     // flit 1 moved
        tick();                     // flit 2 moved
        tail = 5'b00010;
        tick();                     // tail flit moved -> release
        tail = 5'b00000;
        tests++;
        if (grant !== 5'b00000 || sel !== 3'd0) begin
            fails++; $display("FAIL rr_release1: grant=%b sel=%0d want 00000 0", grant, sel);
        end
        tick();
        tests++;
        if (grant !== 5'b00100 || sel !== 3'd2) begin
            fails++; $display("FAIL rr_grant2: grant=%b sel=%0d want 00100 2", grant, sel);
        end
        tail = 5'b00100;
        tick();
        tail = 5'b00000;
        tests++;
        if (grant !== 5'b00000) begin
            fails++; $display("FAIL rr_release2: got %b want %b", grant, 5'b00000);
        end
        tick();
        tests++;
        if (grant !== 5'b10000 || sel !== 3'd4) begin
            fails++; $display("FAIL rr_grant4: grant=%b sel=%0d want 10000 4", grant, sel);
        end
        tail = 5'b10000;
        tick();
        tail = 5'b00000;
        tick();
        tests++;
        if (grant !== 5'b00010 || sel !== 3'd1) begin
            fails++; $display("FAIL rr_wrap1: grant=%b sel=%0d want 00010 1", grant, sel);
        end
    endtask

    task automatic test_stall();
        bit         v_rdy  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        bit   [4:0] v_req  [5] = '{5'b10110, 5'b10110, 5'b10110, 5'b10100, 5'b10110};
        bit   [4:0] v_tail [5] = '{5'b00000, 5'b00010, 5'b00000, 5'b00000, 5'b10000};
        bit         v_xfer [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        bit   [7:0] v_cnt  [5] = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd2};
        do_reset();
        req = 5'b10110;
        tick();
        tests++;
        if (dut.flit_cnt_q !== 8'd0) begin
            fails++; $display("FAIL stall_cnt_init: got %0d want 0", dut.flit_cnt_q);
        end
        for (int c = 0; c < 5; c++) begin
            out_ready = v_rdy[c];
            req       = v_req[c];
            tail      = v_tail[c];
            #1;
            tests++;
            if (xfer !== v_xfer[c]) begin
                fails++; $display("FAIL stall_xfer[%0d]: got %b want %b", c, xfer, v_xfer[c]);
            end
            tick();
            tests++;
            if (grant !== 5'b00010 || sel !== 3'd1) begin
                fails++;
                $display("FAIL stall_hold[%0d]: grant=%b sel=%0d want 00010 1", c, grant, sel);
            end
            tests++;
            if (dut.flit_cnt_q !== v_cnt[c]) begin
                fails++;
                $display("FAIL stall_cnt[%0d]: got %0d want %0d", c, dut.flit_cnt_q, v_cnt[c]);
            end
        end
        tail = '0;
    endtask

    task automatic test_max_pkt();
        do_reset();
        req       = 5'b01000;
        out_ready = 1'b1;
        tick();
        tests++;
        if (grant !== 5'b01000 || sel !== 3'd3) begin
            fails++; $display("FAIL max_grant: grant=%b sel=%0d want 01000 3", grant, sel);
        end
        for (int f = 1; f <= 3; f++) begin
            tick();
            tests++;
            if (grant !== 5'b01000 || pkt_err !== 1'b0) begin
                fails++;
                $display("FAIL max_flit[%0d]: grant=%b pkt_err=%b want 01000 0", f, grant, pkt_err);
            end
        end
        tick();
        tests++;
        if (grant !== 5'b00000 || pkt_err !== 1'b1) begin
            fails++;
            $display("FAIL max_release: grant=%b pkt_err=%b want 00000 1", grant, pkt_err);
        end
        tick();
        tests++;
        if (grant !== 5'b01000) begin
            fails++; $display("FAIL max_regrant: got %b want %b", grant, 5'b01000);
        end
        tail = 5'b01000;
        tick();
        tail = 5'b00000;
        tests++;
        if (grant !== 5'b00000 || pkt_err !== 1'b1) begin
            fails++;
            $display("FAIL max_sticky: grant=%b pkt_err=%b want 00000 1", grant, pkt_err);
        end
    endtask

    task automatic test_enable();
        do_reset();
        en  = 1'b0;
        req = 5'b00001;
        out_ready = 1'b1;
        tick();
        tests++;
        if (grant !== 5'b00000) begin
            fails++; $display("FAIL en_no_arb: got %b want %b", grant, 5'b00000);
        end
        en = 1'b1;
        tick();
        tests++;
        if (grant !== 5'b00001 || sel !== 3'd0) begin
            fails++; $display("FAIL en_grant: grant=%b sel=%0d want 00001 0", grant, sel);
        end
        tick();                     // one flit moved
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if (xfer !== 1'b0) begin
                fails++; $display("FAIL en_xfer[%0d]: got %b want 0", c, xfer);
            end
            tick();
            tests++;
            if (grant !== 5'b00001 || dut.flit_cnt_q !== 8'd1) begin
                fails++;
                $display("FAIL en_hold[%0d]: grant=%b cnt=%0d want 00001 1",
                         c, grant, dut.flit_cnt_q);
            end
        end
        en = 1'b1;
        tick();
        tests++;
        if (dut.flit_cnt_q !== 8'd2 || grant !== 5'b00001) begin
            fails++;
            $display("FAIL en_resume: cnt=%0d grant=%b want 2 00001", dut.flit_cnt_q, grant);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req       = 5'b00100;
        out_ready = 1'b1;
        tick();                     // owner 2
        for (int f = 0; f < 4; f++) tick();  // forced release, pkt_err set
        tick();                     // regranted, busy again
        tests++;
        if (grant !== 5'b00100 || pkt_err !== 1'b1) begin
            fails++;
            $display("FAIL arst_setup: grant=%b pkt_err=%b want 00100 1", grant, pkt_err);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (grant !== 5'b00000 || sel !== 3'd0 || pkt_err !== 1'b0 || xfer !== 1'b0) begin
            fails++;
            $display("FAIL arst_now: grant=%b sel=%0d pkt_err=%b xfer=%b want 00000 0 0 0",
                     grant, sel, pkt_err, xfer);
        end
        #1;
        rst_n = 1'b1;
        req   = 5'b11111;
        tick();
        tests++;
        if (grant !== 5'b00001 || sel !== 3'd0) begin
            fails++; $display("FAIL arst_regrant: grant=%b sel=%0d want 00001 0", grant, sel);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        req       = '0;
        tail      = '0;
        out_ready = 1'b0;
        test_reset();
        test_first_grant();
        test_round_robin();
        test_stall();
        test_max_pkt();
        test_enable();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/port_arbiter.md
PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 Parameter: N_IN, 5, number of requesting input ports (0=LOCAL, 1=X1, 2=X2, 3=Y1, 4=Y2).
REQ-002 Parameter: MAX_PKT, 16, maximum flits per packet before forced release (range 2..255).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  global enable; low freezes all state.
REQ-006 req  input  N_IN  per-input request for this output port; a flit is present while high.
REQ-007 tail  input  N_IN  per-input tail marker; qualifies the flit currently offered on that input.
REQ-008 out_ready  input  1  downstream buffer can accept a flit this cycle.
REQ-009 grant  output  N_IN  registered one-hot owner of the output port; all-zero when free.
REQ-010 sel  output  3  registered binary index of the owner; 0 when free.
REQ-011 xfer  output  1  combinational; a flit moves this cycle.
REQ-012 pkt_err  output  1  sticky flag; a packet exceeded MAX_PKT flits.

Function
REQ-013 FSM SHALL have two states: IDLE (port free) and BUSY (port locked to one input).
REQ-014 In IDLE with en=1 and req!=0, the arbiter SHALL select the first set req bit searching from (rr_ptr+1) mod N_IN upward with wrap.
REQ-015 The selected input SHALL see grant/sel asserted on the following cycle, with state BUSY; grant latency is 1 cycle.
REQ-016 xfer SHALL equal en & BUSY & req[sel] & out_ready; no other term.
REQ-017 In BUSY the grant SHALL be held regardless of req (wormhole lock); req[sel]=0 only stalls transfer.
REQ-018 A 8-bit flit_cnt SHALL clear on entry to BUSY and increment on each xfer.
REQ-019 On xfer with tail[sel]=1, next cycle: grant=0, sel=0, state IDLE, rr_ptr<=sel.
REQ-020 On xfer with tail[sel]=0 and flit_cnt=MAX_PKT-1, the block SHALL force release as in REQ-019 and set pkt_err.
REQ-021 After any release, IDLE SHALL last at least one cycle; no back-to-back regrant in the release cycle.
REQ-022 Requests from non-owners during BUSY SHALL be ignored; no state is kept per waiting requester.
REQ-023 With en=0, state, grant, sel, rr_ptr, flit_cnt SHALL hold; xfer=0; no arbitration.
REQ-024 tail on non-owner inputs and tail on the owner without xfer SHALL have no effect.
REQ-025 pkt_err SHALL clear only on reset.

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE, grant=0, sel=0, flit_cnt=0, pkt_err=0, rr_ptr=N_IN-1 (input 0 highest first priority).
REQ-027 Reset mid-packet SHALL drop the lock immediately; xfer=0 while rst_n low; first grant after release follows REQ-014/REQ-015.

Verification
REQ-028 Reset, then req=5'b10110 at cycle 1 -> grant=5'b00010, sel=1 at cycle 2; xfer=1 when out_ready=1.
REQ-029 Owner 1 sends 3 flits, tail on 3rd with req 5'b10110 held -> grant=0 one cycle, then grant=5'b00100 (sel=2); next packet end -> grant=5'b10000 (sel=4), then 5'b00010.
REQ-030 Owner locked, out_ready toggled 1,0,0,1 and req[sel] dropped one cycle -> xfer only on ready&req cycles, grant never changes, flit_cnt counts xfer only.
REQ-031 MAX_PKT=4, owner 3 sends 4 flits with tail=0 -> release after 4th xfer, pkt_err=1 and stays 1 across later packets.
REQ-032 en=0 for 3 cycles mid-packet with out_ready=1 -> xfer=0, grant/flit_cnt unchanged; en=1 resumes counting from held value.
REQ-033 rst_n asserted asynchronously between edges during BUSY -> grant=0, sel=0, pkt_err=0 immediately; after deassert req=5'b11111 -> grant=5'b00001.
